alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Parametrised successor to the ALU operation controller in the complex-arithmetic datapath.
- Accepts an opcode on `start`, issues it to the ALU, and waits for the ALU's `alu_valid` handshake under a per-operation cycle budget.
- Latches the result into the output register, or reports an illegal opcode, a timeout or an abort.
- Sits between the command/top-level FSM and the ALU (`alux`).

Parameters:
- DATA_W, 64, width of ALU result and `out`.
- CNT_W, 6, width of the cycle budget `maxclock` and the internal counter.
- OPR_W, 4, opcode width.

Ports:
- clock  in  1  master clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  command request; sampled only in IDLE.
- opr  in  OPR_W  opcode, sampled with `start`.
- maxclock  in  CNT_W  cycle budget, sampled with `start`.
- abort  in  1  cancel the current operation.
- alu_valid  in  1  ALU result-ready strobe.
- alu_result  in  DATA_W  ALU result.
- alu_start  out  1  one-cycle issue pulse to the ALU.
- alu_opr  out  OPR_W  registered opcode driven to the ALU.
- out  out  DATA_W  result register.
- out_opr  out  OPR_W  opcode of the last result captured into `out`.
- out_valid  out  1  one-cycle pulse when `out` updates.
- busy  out  1  high whenever state is not IDLE.
- err_illegal  out  1  one-cycle pulse on a rejected opcode.
- err_timeout  out  1  one-cycle pulse when the budget expires.

Behaviour:
- Reset, asynchronous: state=IDLE; counter, `out`, `out_opr`, `alu_opr` = 0; all strobes and `busy` = 0. Reset mid-operation discards the operation and does not update `out`.
- Legal opcodes: 0000 loadA, 0001 loadB, 0010 add, 0011 sub, 0100 cmul, 0110 rmul, 1000 eq, 1001 modA, 1010 modB. All other opcodes are illegal.
- States: IDLE, EXEC, DONE.
- IDLE:
  - `start` with a legal `opr`: `alu_opr`<=`opr`, budget register<=`maxclock`, counter<=0, `alu_start`<=1 for exactly one cycle, which is the first EXEC cycle; go to EXEC.
  - `start` with an illegal `opr`: `err_illegal` pulses the next cycle; stay in IDLE.
  - `alu_valid` in IDLE is ignored.
- EXEC, evaluated in priority order each cycle:
  1. `abort`: go to IDLE; no result, no error.
  2. `alu_valid`: `out`<=`alu_result`, `out_opr`<=`alu_opr`; go to DONE.
  3. counter==budget: `err_timeout` pulses the next cycle; go to IDLE; `out` is unchanged.
  4. Otherwise counter<=counter+1.
- Budget semantics:
  - With budget N, `alu_valid` is accepted in EXEC cycles 0..N, i.e. N+1 cycles.
  - The timeout flags at the end of EXEC cycle N if no `alu_valid` arrived.
  - Budget 0 allows exactly one cycle.
  - The counter never exceeds the budget and never wraps.
- DONE: `out_valid`=1 for exactly one cycle; unconditional return to IDLE.
- Latency: `start` edge to `out_valid` = k+2 cycles, where `alu_valid` arrives in EXEC cycle k.
- `busy`: high in EXEC and DONE. `start` while `busy` is ignored and flags no error.
- Back-to-back operation: a new `start` is accepted in the first IDLE cycle after DONE or after a timeout.
- `out` and `out_opr` hold their values until the next successful capture; they are unaffected by abort, timeout or illegal opcodes.
- `maxclock` and `opr` changes during EXEC have no effect.
- All outputs are registered.

Test Plan:
- Reset, then `start`, opr=0010, maxclock=5; `alu_valid` with alu_result=0x0000_0003_0000_0004 in EXEC cycle 2 -> `alu_start` high on cycle 1 only; `out`=0x0000_0003_0000_0004, `out_opr`=0010, `out_valid` 1 cycle at `start`+4; `busy` low afterwards.
- opr=0100, maxclock=3, `alu_valid` never asserted -> `err_timeout` pulses exactly once after 4 EXEC cycles; `out` keeps its prior value; `out_valid` stays 0.
- opr=0101 with `start` -> `err_illegal` one-cycle pulse; `busy` stays 0; no `alu_start`.
- maxclock=0, `alu_valid` in EXEC cycle 0 -> captured, no timeout. Separately, `alu_valid` and counter==budget in the same cycle -> result captured, no `err_timeout`.
- `abort` asserted together with `alu_valid` in EXEC -> return to IDLE; `out` unchanged; no `out_valid`, no errors.
- Second `start` during EXEC ignored; async reset asserted mid-EXEC -> all outputs 0 immediately; next `start` (opr=1000) behaves normally.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// ALU operation sequencer: issues a legal opcode to the ALU and waits for
// its result under a per-operation cycle budget, reporting illegal opcodes,
// timeouts and aborts.
module alu_op_sequencer #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CNT_W  = 6,
  parameter int unsigned OPR_W  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [OPR_W-1:0]  opr,
  input  logic [CNT_W-1:0]  maxclock,
  input  logic              abort,
  input  logic              alu_valid,
  input  logic [DATA_W-1:0] alu_result,
  output logic              alu_start,
  output logic [OPR_W-1:0]  alu_opr,
  output logic [DATA_W-1:0] out,
  output logic [OPR_W-1:0]  out_opr,
  output logic              out_valid,
  output logic              busy,
  output logic              err_illegal,
  output logic              err_timeout
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    budget_q, budget_d;
  logic [OPR_W-1:0]    alu_opr_q, alu_opr_d;
  logic [DATA_W-1:0]   out_q, out_d;
  logic [OPR_W-1:0]    out_opr_q, out_opr_d;
  logic                alu_start_q, alu_start_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;
  logic                err_illegal_q, err_illegal_d;
  logic                err_timeout_q, err_timeout_d;
  logic                opr_legal;

  // Opcode decode: loadA, loadB, add, sub, cmul, rmul, eq, modA, modB
  always_comb begin
    opr_legal = (opr == OPR_W'(4'h0)) || (opr == OPR_W'(4'h1)) ||
                (opr == OPR_W'(4'h2)) || (opr == OPR_W'(4'h3)) ||
                (opr == OPR_W'(4'h4)) || (opr == OPR_W'(4'h6)) ||
                (opr == OPR_W'(4'h8)) || (opr == OPR_W'(4'h9)) ||
                (opr == OPR_W'(4'hA));
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    budget_d      = budget_q;
    alu_opr_d     = alu_opr_q;
    out_d         = out_q;
    out_opr_d     = out_opr_q;
    alu_start_d   = 1'b0;
    out_valid_d   = 1'b0;
    err_illegal_d = 1'b0;
    err_timeout_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (opr_legal) begin
            alu_opr_d   = opr;
            budget_d    = maxclock;
            cnt_d       = '0;
            alu_start_d = 1'b1;
            state_d     = ST_EXEC;
          end else begin
            err_illegal_d = 1'b1;
          end
        end
      end
      ST_EXEC: begin
        // Abort beats a same-cycle result; a result beats an expiring budget
        if (abort) begin
          state_d = ST_IDLE;
        end else if (alu_valid) begin
          out_d       = alu_result;
          out_opr_d   = alu_opr_q;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else if (cnt_q == budget_q) begin
          err_timeout_d = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      budget_q      <= '0;
      alu_opr_q     <= '0;
      out_q         <= '0;
      out_opr_q     <= '0;
      alu_start_q   <= 1'b0;
      out_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      err_illegal_q <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      budget_q      <= budget_d;
      alu_opr_q     <= alu_opr_d;
      out_q         <= out_d;
      out_opr_q     <= out_opr_d;
      alu_start_q   <= alu_start_d;
      out_valid_q   <= out_valid_d;
      busy_q        <= busy_d;
      err_illegal_q <= err_illegal_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign alu_start   = alu_start_q;
  assign alu_opr     = alu_opr_q;
  assign out         = out_q;
  assign out_opr     = out_opr_q;
  assign out_valid   = out_valid_q;
  assign busy        = busy_q;
  assign err_illegal = err_illegal_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: a directed vector table plus
// hand-written timeout and mid-operation reset sequences.
module tb_alu_op_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  opr = '0;
  logic [5:0]  maxclock = '0;
  logic        abort = 1'b0;
  logic        alu_valid = 1'b0;
  logic [63:0] alu_result = '0;
  logic        alu_start;
  logic [3:0]  alu_opr;
  logic [63:0] out;
  logic [3:0]  out_opr;
  logic        out_valid;
  logic        busy;
  logic        err_illegal;
  logic        err_timeout;

  int total = 0;
  int bad   = 0;

  alu_op_sequencer #(.DATA_W(64), .CNT_W(6), .OPR_W(4)) dut (
    .clock(clock), .reset(reset), .start(start), .opr(opr),
    .maxclock(maxclock), .abort(abort), .alu_valid(alu_valid),
    .alu_result(alu_result), .alu_start(alu_start), .alu_opr(alu_opr),
    .out(out), .out_opr(out_opr), .out_valid(out_valid), .busy(busy),
    .err_illegal(err_illegal), .err_timeout(err_timeout)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        start;
    logic [3:0]  opr;
    logic [5:0]  maxclock;
    logic        abort;
    logic        alu_valid;
    logic [63:0] alu_result;
    logic        e_alu_start;
    logic [3:0]  e_alu_opr;
    logic        e_out_valid;
    logic        e_busy;
    logic        e_err_illegal;
    logic        e_err_timeout;
    logic [63:0] e_out;
    logic [3:0]  e_out_opr;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; opr = '0; maxclock = '0; abort = 1'b0;
    alu_valid = 1'b0; alu_result = '0;
  endtask

  task automatic add_vec(input logic s, input logic [3:0] o, input logic [5:0] m,
                         input logic ab, input logic av, input logic [63:0] r,
                         input logic eas, input logic [3:0] eao, input logic eov,
                         input logic eb, input logic eil, input logic eto,
                         input logic [63:0] eout, input logic [3:0] eoo);
    vec_t v;
    v.start = s; v.opr = o; v.maxclock = m; v.abort = ab;
    v.alu_valid = av; v.alu_result = r;
    v.e_alu_start = eas; v.e_alu_opr = eao; v.e_out_valid = eov; v.e_busy = eb;
    v.e_err_illegal = eil; v.e_err_timeout = eto; v.e_out = eout; v.e_out_opr = eoo;
    vecs.push_back(v);
  endtask

  task automatic chk_all(input string tag, input logic eas, input logic [3:0] eao,
                         input logic eov, input logic eb, input logic eil,
                         input logic eto, input logic [63:0] eout, input logic [3:0] eoo);
    chk({tag, ".alu_start"},   64'(alu_start),   64'(eas));
    chk({tag, ".alu_opr"},     64'(alu_opr),     64'(eao));
    chk({tag, ".out_valid"},   64'(out_valid),   64'(eov));
    chk({tag, ".busy"},        64'(busy),        64'(eb));
    chk({tag, ".err_illegal"}, 64'(err_illegal), 64'(eil));
    chk({tag, ".err_timeout"}, 64'(err_timeout), 64'(eto));
    chk({tag, ".out"},         out,              eout);
    chk({tag, ".out_opr"},     64'(out_opr),     64'(eoo));
  endtask

  initial begin
    int to_pulses;
    int ov_pulses;
    localparam logic [63:0] R0 = 64'h0000_0003_0000_0004;

    //       st opr  max ab av result          | as aopr ov bz il to out      oopr
    add_vec(1, 4'h2, 5, 0, 0, 64'h0,           1, 4'h2, 0, 1, 0, 0, 64'h0,  4'h0);
    add_vec(0, 4'h0, 0, 0, 0, 64'h0,           0, 4'h2, 0, 1, 0, 0, 64'h0,  4'h0);
    add_vec(0, 4'h0, 0, 0, 0, 64'h0,           0, 4'h2, 0, 1, 0, 0, 64'h0,  4'h0);
    add_vec(0, 4'h0, 0, 0, 1, R0,              0, 4'h2, 1, 1, 0, 0, R0,     4'h2);
    add_vec(0, 4'h0, 0, 0, 0, 64'h0,           0, 4'h2, 0, 0, 0, 0, R0,     4'h2);
    add_vec(1, 4'h5, 0, 0, 0, 64'h0,           0, 4'h2, 0, 0, 1, 0, R0,     4'h2);
    add_vec(0, 4'h0, 0, 0, 0, 64'h0,           0, 4'h2, 0, 0, 0, 0, R0,     4'h2);
    add_vec(1, 4'h8, 0, 0, 0, 64'h0,           1, 4'h8, 0, 1, 0, 0, R0,     4'h2);
    add_vec(0, 4'h0, 0, 0, 1, 64'hAA,          0, 4'h8, 1, 1, 0, 0, 64'hAA, 4'h8);
    add_vec(0, 4'h0, 0, 0, 0, 64'h0,           0, 4'h8, 0, 0, 0, 0, 64'hAA, 4'h8);
    add_vec(1, 4'h1, 0, 0, 0, 64'h0,           1, 4'h1, 0, 1, 0, 0, 64'hAA, 4'h8);
    add_vec(0, 4'h0, 0, 0, 0, 64'h0,           0, 4'h1, 0, 0, 0, 1, 64'hAA, 4'h8);
    add_vec(1, 4'h3, 1, 0, 0, 64'h0,           1, 4'h3, 0, 1, 0, 0, 64'hAA, 4'h8);
    add_vec(0, 4'h0, 0, 0, 0, 64'h0,           0, 4'h3, 0, 1, 0, 0, 64'hAA, 4'h8);
    add_vec(0, 4'h0, 0, 0, 1, 64'h55,          0, 4'h3, 1, 1, 0, 0, 64'h55, 4'h3);
    add_vec(1, 4'h9, 2, 0, 0, 64'h0,           0, 4'h3, 0, 0, 0, 0, 64'h55, 4'h3);
    add_vec(1, 4'h9, 2, 0, 0, 64'h0,           1, 4'h9, 0, 1, 0, 0, 64'h55, 4'h3);
    add_vec(0, 4'h0, 0, 1, 1, 64'hDEAD,        0, 4'h9, 0, 0, 0, 0, 64'h55, 4'h3);
    add_vec(1, 4'hA, 1, 0, 0, 64'h0,           1, 4'hA, 0, 1, 0, 0, 64'h55, 4'h3);
    add_vec(1, 4'h5, 0, 0, 0, 64'h0,           0, 4'hA, 0, 1, 0, 0, 64'h55, 4'h3);
    add_vec(0, 4'h0, 0, 0, 1, 64'h77,          0, 4'hA, 1, 1, 0, 0, 64'h77, 4'hA);
    add_vec(0, 4'h0, 0, 0, 0, 64'h0,           0, 4'hA, 0, 0, 0, 0, 64'h77, 4'hA);
    add_vec(0, 4'h0, 0, 0, 1, 64'h99,          0, 4'hA, 0, 0, 0, 0, 64'h77, 4'hA);

    // Reset state
    idle_inputs();
    repeat (2) step();
    chk_all("reset", 0, 4'h0, 0, 0, 0, 0, 64'h0, 4'h0);
    @(negedge clock);
    reset = 1'b0;

    foreach (vecs[i]) begin
      start = vecs[i].start; opr = vecs[i].opr; maxclock = vecs[i].maxclock;
      abort = vecs[i].abort; alu_valid = vecs[i].alu_valid;
      alu_result = vecs[i].alu_result;
      step();
      chk_all($sformatf("v%0d", i), vecs[i].e_alu_start, vecs[i].e_alu_opr,
              vecs[i].e_out_valid, vecs[i].e_busy, vecs[i].e_err_illegal,
              vecs[i].e_err_timeout, vecs[i].e_out, vecs[i].e_out_opr);
    end
    idle_inputs();

    // Timeout with budget 3: four EXEC cycles, then a single err_timeout pulse
    start = 1'b1; opr = 4'h4; maxclock = 6'd3;
    step();
    chk_all("to.issue", 1, 4'h4, 0, 1, 0, 0, 64'h77, 4'hA);
    idle_inputs();
    to_pulses = 0;
    ov_pulses = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (err_timeout) to_pulses++;
      if (out_valid) ov_pulses++;
      chk($sformatf("to.c%0d.busy", k), 64'(busy), 64'(k < 3));
      chk($sformatf("to.c%0d.err_timeout", k), 64'(err_timeout), 64'(k == 3));
    end
    for (int k = 0; k < 3; k++) begin
      step();
      if (err_timeout) to_pulses++;
      if (out_valid) ov_pulses++;
    end
    chk("to.pulses", 64'(to_pulses), 64'd1);
    chk("to.out_valid_pulses", 64'(ov_pulses), 64'd0);
    chk("to.out_held", out, 64'h77);
    chk("to.out_opr_held", 64'(out_opr), 64'hA);

    // Asynchronous reset mid-EXEC clears everything without a clock edge
    start = 1'b1; opr = 4'h2; maxclock = 6'd5;
    step();
    idle_inputs();
    step();
    chk("rst.pre.busy", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    chk_all("rst.async", 0, 4'h0, 0, 0, 0, 0, 64'h0, 4'h0);
    @(negedge clock);
    reset = 1'b0;
    start = 1'b1; opr = 4'h8; maxclock = 6'd4;
    step();
    chk_all("post.issue", 1, 4'h8, 0, 1, 0, 0, 64'h0, 4'h0);
    idle_inputs();
    alu_valid = 1'b1; alu_result = 64'h1234;
    step();
    chk_all("post.done", 0, 4'h8, 1, 1, 0, 0, 64'h1234, 4'h8);
    idle_inputs();
    step();
    chk_all("post.idle", 0, 4'h8, 0, 0, 0, 0, 64'h1234, 4'h8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
